// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM state encoding
// and elaboration-time helpers for chunk count and chunk-index width.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunks per operand; guarded so a bad CHUNK does not divide by zero
    function automatic int calc_nch(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    // Chunk index width, never narrower than one bit so NCH=1 still has a counter
    function automatic int calc_idx_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// rca_chunk: purely combinational CHUNK-bit ripple-carry chain of full adders.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit add/subtract computed CHUNK bits per cycle with
// the carry held in a register between chunks. valid/ready on both sides.
// Optional signed-overflow output enabled by defining SEQ_CHUNK_ADDER_OVF_EN;
// without it ovf is tied low and the port is kept.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH   = calc_nch(WIDTH, CHUNK);
    localparam int IDX_W = calc_idx_w(NCH);

    if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK, CHUNK >= 1");
    end

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [IDX_W-1:0]   r_k;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic [CHUNK-1:0]   w_x;
    logic [CHUNK-1:0]   w_y;
    logic [CHUNK-1:0]   w_s;
    logic               w_co;
    logic               w_last;
    logic               w_accept;

    assign w_x      = r_a[int'(r_k)*CHUNK +: CHUNK];
    assign w_y      = r_b[int'(r_k)*CHUNK +: CHUNK];
    assign w_last   = (r_k == IDX_W'(NCH - 1));
    assign w_accept = in_valid && (r_state == IDLE);

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .x  (w_x),
        .y  (w_y),
        .ci (r_c),
        .s  (w_s),
        .co (w_co)
    );

    // Next-state logic: accept only in IDLE, leave DONE only on consumer handshake
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic r_ovf;
`endif

    // Datapath: latch operands (B inverted for subtract), then one chunk per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_k    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a <= a;
                r_b <= sub ? ~b : b;
                r_c <= sub ? ~cin : cin;
                r_k <= '0;
            end else if (r_state == RUN) begin
                r_sum[int'(r_k)*CHUNK +: CHUNK] <= w_s;
                r_c <= w_co;
                r_k <= r_k + IDX_W'(1);
                if (w_last) begin
                    r_cout <= w_co;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                    // Last chunk's top sum bit is the result MSB
                    r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[CHUNK-1] != r_a[WIDTH-1]);
`endif
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    assign ovf       = r_ovf;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4): directed cases
// plus random operations compared against an integer-arithmetic model.
module tb_seq_chunk_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_chk = 0;
    int n_err = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                         input logic sub_i, output logic [15:0] e_sum, output logic e_cout,
                         output logic e_ovf);
        int u;
        int s;
        if (sub_i) begin
            u = int'(a_i) - int'(b_i) - int'(cin_i);
            s = int'($signed(a_i)) - int'($signed(b_i)) - int'(cin_i);
            e_cout = (u >= 0);
        end else begin
            u = int'(a_i) + int'(b_i) + int'(cin_i);
            s = int'($signed(a_i)) + int'($signed(b_i)) + int'(cin_i);
            e_cout = (u > 65535);
        end
        e_sum = u[15:0];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        e_ovf = (s > 32767) || (s < -32768);
`else
        e_ovf = 1'b0;
`endif
    endtask

    // One full transaction; stall = cycles out_ready held low in DONE, pulse = in_valid during RUN
    task automatic do_op(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                         input logic sub_i, input int stall, input bit pulse, input string tag);
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        int          n;
        model(a_i, b_i, cin_i, sub_i, e_sum, e_cout, e_ovf);
        out_ready = (stall == 0);
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = a_i; b = b_i; cin = cin_i; sub = sub_i;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            in_valid = pulse && (n == 1);
            if (!out_valid && in_ready) chk({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'(NCH));
        chk({tag, ".sum"},  32'(sum),  32'(e_sum));
        chk({tag, ".cout"}, 32'(cout), 32'(e_cout));
        chk({tag, ".ovf"},  32'(ovf),  32'(e_ovf));
        chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_sum"},   32'(sum),       32'(e_sum));
            chk({tag, ".hold_cout"},  32'(cout),      32'(e_cout));
            chk({tag, ".hold_rdy"},   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.sum",       32'(sum),       32'd0);
        chk("reset.cout",      32'(cout),      32'd0);
        chk("reset.ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "add_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "ripple");
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "ripple_cin");
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, "sub_borrow");
        do_op(16'h0009, 16'h0002, 1'b1, 1'b1, 0, 1'b0, "sub_cin");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "ovf_add");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, "ovf_sub");
        do_op(16'h1357, 16'h2468, 1'b0, 1'b0, 3, 1'b1, "backpressure");

        // Reset during the second RUN cycle aborts the operation
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready",  32'(in_ready),  32'd1);
        chk("midrst.sum",       32'(sum),       32'd0);
        chk("midrst.cout",      32'(cout),      32'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, "after_rst");
        chk("after_rst.value", 32'(sum), 32'h2345);

        for (int i = 0; i < 30; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
